last_level_cache: RTL and testbench
===================================

// Module: last_level_cache
// PURPOSE
// - Set-associative last-level cache model: write-allocate, MESI coherence, tree pseudo-LRU replacement.
// - Processes one trace command (CPU access, snoop, or maintenance) per clock.
// - Keeps read/write/hit/miss statistics; emits bus-op, writeback and snoop-result strobes.
// - Sits below the trace driver, which feeds command/address/strobe and reads the counters.
// PARAMETERS
// - ADDR_BITS   32  byte-address width
// - CMDSIZE     4   command code width
// - SETS        64  number of sets (power of 2)
// - WAYS        4   associativity (power of 2, >=2)
// - LINE_BYTES  64  line size (power of 2)
// PORTS
// - clk           in   1          system clock, rising edge
// - rst           in   1          synchronous, active-high reset
// - command       in   CMDSIZE    trace command code
// - address       in   ADDR_BITS  byte address
// - eof           in   1          command-valid strobe (high = process command this cycle)
// - mode          in   1          0 = normal (messages allowed), 1 = silent
// - reads         out  32         CPU read count (cmd 0, 2)
// - writes        out  32         CPU write count (cmd 1)
// - cache_hits    out  32         CPU-access hit count
// - cache_misses  out  32         CPU-access miss count
// - bus_op        out  3          0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
// - wb            out  1          dirty line written back this command
// - snoop_result  out  2          0 HIT, 1 HITM, 2 NOHIT
// BEHAVIOUR
// - Clock and reset: one clock; rst synchronous, active-high.
// - Reset: all lines I, PLRU bits 0, counters 0, bus_op=0, wb=0, snoop_result=2.
//   A command present during rst is dropped.
// - Address split: offset=log2(LINE_BYTES) LSBs; index=next log2(SETS) bits; tag=remaining MSBs.
// - Command acceptance: a command is taken at each rising clk with eof=1.
//   Results are registered 1 cycle later; bus_op, wb and snoop_result are single-cycle pulses, else 0/0/2.
// - Counters wrap at 2^32.
// - Own snoop result (used on a miss) = address[1:0]: 00 HIT, 01 HITM, 1x NOHIT.
// - Victim selection: lowest-index invalid way first, else the PLRU victim.
// - PLRU tree (WAYS-1 bits per set): node bit 0 = victim in the lower half.
//   Every CPU hit or fill sets the nodes on its path to point away from the accessed way.
// - Victim in state M sets wb=1.
// - cmd 0/2 read:
//   - Hit: state kept, hits++.
//   - Miss: misses++, bus_op=READ, fill E if own snoop result is NOHIT, else S.
//   - reads++ in both cases.
// - cmd 1 write: writes++.
//   - Hit: M->M and E->M with no bus op; S->M with bus_op=INVALIDATE.
//   - Miss: bus_op=RWIM, fill M.
// - cmd 3 snoop invalidate: S->I; other states unchanged.
// - cmd 4 snoop read: M->S (HITM, wb=1); E->S (HIT); S (HIT); miss/I (NOHIT).
// - cmd 5 snoop write: no effect; snoop_result=NOHIT.
// - cmd 6 snoop RWIM: M->I (HITM, wb=1); E/S->I (HIT); miss (NOHIT).
// - Snoop commands do not change counters or PLRU.
// - cmd 8: all lines I, PLRU 0, all counters 0.
// - cmd 9: no state change.
// - Codes 7 and 10..15: ignored; no counter or strobe activity.
// CONFIGURATION
// - LLC_TRACE_EN defined:
//   - When mode=0: $display per command (cmd, address, hit/miss, bus_op, wb, snoop_result).
//   - cmd 9 dumps every valid line (set, way, tag, MESI state).
//   - mode=1 suppresses all output.
// - LLC_TRACE_EN undefined: no $display code is compiled; cmd 9 is a pure no-op. Datapath is identical either way.
// TESTING
// - Read fill: rst; cmd0 @0x00001002 -> miss, bus_op=1, line E, reads=1, misses=1.
//   Repeat cmd0 @0x00001002 -> hits=1, bus_op=0.
// - Write upgrade: cmd1 @0x00001002 (E) -> M, bus_op=0, writes=1.
//   cmd4 @0x00001002 -> snoop_result=1, wb=1, line S.
//   cmd1 again -> bus_op=3, line M.
// - Eviction: cmd0 to 0x00001002, 0x00002002, 0x00003002, 0x00004002 (set 0) -> 4 misses.
//   cmd0 @0x00005002 -> evicts way 0; cmd0 @0x00001002 -> miss.
// - Snoop invalidate: cmd6 on an M line -> wb=1, snoop_result=1, line I.
//   cmd3 on an S line -> line I; next cmd0 on it misses.
// - Clear: after traffic, cmd8 -> reads=writes=cache_hits=cache_misses=0; prior-hit address now misses.
// - Reset mid-run: rst=1 with eof=1, cmd0 -> command dropped, all counters 0, bus_op=0.

Source files
------------

// File: rtl/last_level_cache.sv
`default_nettype none
// ============================================================================
// Module      : last_level_cache
// Description : Set-associative last-level cache model. Write-allocate,
//               MESI coherence and tree pseudo-LRU replacement. Handles one
//               trace command (CPU access, snoop or maintenance) per clock.
//               Keeps read/write/hit/miss statistics and pulses bus-op,
//               writeback and snoop-result strobes for one cycle.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               command, address  - trace command code and byte address
//               eof               - command valid this cycle
//               mode              - 0 normal (messages allowed), 1 silent
//               reads, writes, cache_hits, cache_misses - 32-bit counters
//               bus_op            - 0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
//               wb                - dirty victim/line written back
//               snoop_result      - 0 HIT, 1 HITM, 2 NOHIT
// Options     : LLC_TRACE_EN - when defined, prints one line per command
//               (mode=0) and dumps all valid lines on command 9.
// Revision    : 1.0 - initial release
// ============================================================================
module last_level_cache #(
    parameter int ADDR_BITS  = 32,
    parameter int CMDSIZE    = 4,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMDSIZE-1:0]   command,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 eof,
    input  logic                 mode,
    output logic [31:0]          reads,
    output logic [31:0]          writes,
    output logic [31:0]          cache_hits,
    output logic [31:0]          cache_misses,
    output logic [2:0]           bus_op,
    output logic                 wb,
    output logic [1:0]           snoop_result
);

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_BITS - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int PLRU_BITS = WAYS - 1;

    localparam logic [CMDSIZE-1:0] CMD_READ     = CMDSIZE'(0);
    localparam logic [CMDSIZE-1:0] CMD_WRITE    = CMDSIZE'(1);
    localparam logic [CMDSIZE-1:0] CMD_IFETCH   = CMDSIZE'(2);
    localparam logic [CMDSIZE-1:0] CMD_SNP_INV  = CMDSIZE'(3);
    localparam logic [CMDSIZE-1:0] CMD_SNP_RD   = CMDSIZE'(4);
    localparam logic [CMDSIZE-1:0] CMD_SNP_WR   = CMDSIZE'(5);
    localparam logic [CMDSIZE-1:0] CMD_SNP_RWIM = CMDSIZE'(6);
    localparam logic [CMDSIZE-1:0] CMD_CLEAR    = CMDSIZE'(8);
    localparam logic [CMDSIZE-1:0] CMD_DUMP     = CMDSIZE'(9);

    localparam logic [2:0] BUS_NONE  = 3'd0;
    localparam logic [2:0] BUS_READ  = 3'd1;
    localparam logic [2:0] BUS_INVAL = 3'd3;
    localparam logic [2:0] BUS_RWIM  = 3'd4;

    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd1;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [TAG_BITS-1:0]  r_tag   [SETS][WAYS];
    mesi_t                r_state [SETS][WAYS];
    // Heap-ordered tree: node n (1-based) lives in bit n-1; children 2n, 2n+1.
    logic [PLRU_BITS-1:0] r_plru  [SETS];

    // ------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0] w_tag;

    assign w_index = address[OFF_BITS +: IDX_BITS];
    assign w_tag   = address[ADDR_BITS-1 -: TAG_BITS];

    // Offset bits above [1:0] play no part in this model.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, address[OFF_BITS-1:2], mode};

    // ------------------------------------------------------------------
    // Lookup, victim selection, PLRU update
    // ------------------------------------------------------------------
    logic                 w_hit;
    logic [WAY_BITS-1:0]  w_hit_way;
    logic                 w_has_inv;
    logic [WAY_BITS-1:0]  w_inv_way;
    logic [WAY_BITS-1:0]  w_plru_way;
    logic [WAY_BITS-1:0]  w_way;
    mesi_t                w_cur;
    mesi_t                w_vict_state;
    logic [PLRU_BITS-1:0] w_plru_next;
    logic [WAY_BITS:0]    w_node;
    logic [WAY_BITS-1:0]  w_node_idx;
    logic [WAY_BITS-1:0]  w_way_sh;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_has_inv  = 1'b0;
        w_inv_way  = '0;
        w_node     = (WAY_BITS+1)'(1);
        w_node_idx = '0;
        w_way_sh   = '0;

        for (int w = 0; w < WAYS; w++) begin
            if (r_state[w_index][w] != MESI_I && r_tag[w_index][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
        end

        // Scan downwards so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_state[w_index][w] == MESI_I) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_BITS'(w);
            end
        end

        // Follow the tree from the root: bit 0 sends us to the lower half.
        for (int l = 0; l < WAY_BITS; l++) begin
            w_node_idx = w_node[WAY_BITS-1:0] - 1'b1;
            w_node     = {w_node[WAY_BITS-1:0], r_plru[w_index][w_node_idx]};
        end
        w_plru_way = w_node[WAY_BITS-1:0];

        w_way        = w_hit ? w_hit_way : (w_has_inv ? w_inv_way : w_plru_way);
        w_cur        = w_hit ? r_state[w_index][w_hit_way] : MESI_I;
        w_vict_state = r_state[w_index][w_way];

        // Re-walk along the accessed way, pointing each node at the other half.
        w_plru_next = r_plru[w_index];
        w_node      = (WAY_BITS+1)'(1);
        w_way_sh    = w_way;
        for (int l = 0; l < WAY_BITS; l++) begin
            w_node_idx              = w_node[WAY_BITS-1:0] - 1'b1;
            w_plru_next[w_node_idx] = ~w_way_sh[WAY_BITS-1];
            w_node                  = {w_node[WAY_BITS-1:0], w_way_sh[WAY_BITS-1]};
            w_way_sh                = w_way_sh << 1;
        end
    end

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    mesi_t      w_next_state;
    logic       w_state_we;
    logic       w_fill;
    logic       w_touch;
    logic [2:0] w_bus;
    logic       w_wb;
    logic [1:0] w_snoop;
    logic       w_inc_read;
    logic       w_inc_write;
    logic       w_inc_hit;
    logic       w_inc_miss;
    logic       w_clear;

    always_comb begin
        w_next_state = w_cur;
        w_state_we   = 1'b0;
        w_fill       = 1'b0;
        w_touch      = 1'b0;
        w_bus        = BUS_NONE;
        w_wb         = 1'b0;
        w_snoop      = SNP_NOHIT;
        w_inc_read   = 1'b0;
        w_inc_write  = 1'b0;
        w_inc_hit    = 1'b0;
        w_inc_miss   = 1'b0;
        w_clear      = 1'b0;

        case (command)
            CMD_READ, CMD_IFETCH: begin
                w_inc_read = 1'b1;
                w_touch    = 1'b1;
                if (w_hit) begin
                    w_inc_hit = 1'b1;
                end else begin
                    w_inc_miss   = 1'b1;
                    w_bus        = BUS_READ;
                    w_wb         = (w_vict_state == MESI_M);
                    w_fill       = 1'b1;
                    w_state_we   = 1'b1;
                    // Exclusive only when no other cache reported holding it.
                    w_next_state = address[1] ? MESI_E : MESI_S;
                end
            end
            CMD_WRITE: begin
                w_inc_write  = 1'b1;
                w_touch      = 1'b1;
                w_state_we   = 1'b1;
                w_next_state = MESI_M;
                if (w_hit) begin
                    w_inc_hit = 1'b1;
                    if (w_cur == MESI_S) begin
                        w_bus = BUS_INVAL;
                    end
                end else begin
                    w_inc_miss = 1'b1;
                    w_bus      = BUS_RWIM;
                    w_wb       = (w_vict_state == MESI_M);
                    w_fill     = 1'b1;
                end
            end
            CMD_SNP_INV: begin
                // Only shared copies can be invalidated by another cache's upgrade;
                // no snoop response is driven for this command.
                if (w_hit && w_cur == MESI_S) begin
                    w_state_we   = 1'b1;
                    w_next_state = MESI_I;
                end
            end
            CMD_SNP_RD: begin
                if (w_hit) begin
                    w_state_we   = 1'b1;
                    w_next_state = MESI_S;
                    if (w_cur == MESI_M) begin
                        w_snoop = SNP_HITM;
                        w_wb    = 1'b1;
                    end else begin
                        w_snoop = SNP_HIT;
                    end
                end
            end
            CMD_SNP_WR: begin
                w_snoop = SNP_NOHIT;
            end
            CMD_SNP_RWIM: begin
                if (w_hit) begin
                    w_state_we   = 1'b1;
                    w_next_state = MESI_I;
                    if (w_cur == MESI_M) begin
                        w_snoop = SNP_HITM;
                        w_wb    = 1'b1;
                    end else begin
                        w_snoop = SNP_HIT;
                    end
                end
            end
            CMD_CLEAR: begin
                w_clear = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, statistics and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_plru[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_state[s][w] <= MESI_I;
                end
            end
            reads        <= '0;
            writes       <= '0;
            cache_hits   <= '0;
            cache_misses <= '0;
            bus_op       <= BUS_NONE;
            wb           <= 1'b0;
            snoop_result <= SNP_NOHIT;
        end else begin
            bus_op       <= BUS_NONE;
            wb           <= 1'b0;
            snoop_result <= SNP_NOHIT;
            if (eof) begin
                if (w_clear) begin
                    for (int s = 0; s < SETS; s++) begin
                        r_plru[s] <= '0;
                        for (int w = 0; w < WAYS; w++) begin
                            r_state[s][w] <= MESI_I;
                        end
                    end
                    reads        <= '0;
                    writes       <= '0;
                    cache_hits   <= '0;
                    cache_misses <= '0;
                end else begin
                    if (w_state_we) begin
                        r_state[w_index][w_way] <= w_next_state;
                    end
                    if (w_touch) begin
                        r_plru[w_index] <= w_plru_next;
                    end
                    reads        <= reads        + 32'(w_inc_read);
                    writes       <= writes       + 32'(w_inc_write);
                    cache_hits   <= cache_hits   + 32'(w_inc_hit);
                    cache_misses <= cache_misses + 32'(w_inc_miss);
                    bus_op       <= w_bus;
                    wb           <= w_wb;
                    snoop_result <= w_snoop;
                end
            end
        end
    end

    // Tags need no reset: a line's tag is meaningless while its state is I.
    always_ff @(posedge clk) begin
        if (!rst && eof && w_fill) begin
            r_tag[w_index][w_way] <= w_tag;
        end
    end

`ifdef LLC_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && eof && !mode) begin
            $display("LLC cmd=%0d addr=%h %s bus_op=%0d wb=%0b snoop=%0d",
                     command, address, w_hit ? "hit" : "miss", w_bus, w_wb, w_snoop);
            if (command == CMD_DUMP) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (r_state[s][w] != MESI_I) begin
                            $display("LLC   set=%0d way=%0d tag=%h state=%s",
                                     s, w, r_tag[s][w], r_state[s][w].name());
                        end
                    end
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_last_level_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_last_level_cache
// Description : Directed self-checking bench for last_level_cache. Each
//               command is applied for one cycle and the registered results
//               are compared against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_last_level_cache;

    logic        clk;
    logic        rst;
    logic [3:0]  command;
    logic [31:0] address;
    logic        eof;
    logic        mode;
    logic [31:0] reads;
    logic [31:0] writes;
    logic [31:0] cache_hits;
    logic [31:0] cache_misses;
    logic [2:0]  bus_op;
    logic        wb;
    logic [1:0]  snoop_result;

    int n_checks = 0;
    int n_errors = 0;

    last_level_cache dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .address      (address),
        .eof          (eof),
        .mode         (mode),
        .reads        (reads),
        .writes       (writes),
        .cache_hits   (cache_hits),
        .cache_misses (cache_misses),
        .bus_op       (bus_op),
        .wb           (wb),
        .snoop_result (snoop_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Apply one command for exactly one accepting edge, then sample.
    task automatic do_cmd(input logic [3:0] cmd, input logic [31:0] addr);
        @(negedge clk);
        command = cmd;
        address = addr;
        eof     = 1'b1;
        @(posedge clk);
        #1;
        eof = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        eof = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic [2:0] e_bus,
                                 input logic e_wb, input logic [1:0] e_snp);
        check({tag, ".bus_op"}, 32'(bus_op), 32'(e_bus));
        check({tag, ".wb"}, 32'(wb), 32'(e_wb));
        check({tag, ".snoop"}, 32'(snoop_result), 32'(e_snp));
    endtask

    task automatic check_ctrs(input string tag, input int e_rd, input int e_wr,
                              input int e_hit, input int e_miss);
        check({tag, ".reads"}, reads, 32'(e_rd));
        check({tag, ".writes"}, writes, 32'(e_wr));
        check({tag, ".hits"}, cache_hits, 32'(e_hit));
        check({tag, ".misses"}, cache_misses, 32'(e_miss));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        command = '0;
        address = '0;
        eof     = 1'b0;
        mode    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_ctrs("reset", 0, 0, 0, 0);
        check_strobes("reset", 3'd0, 1'b0, 2'd2);
        @(negedge clk);
        rst = 1'b0;

        // Read fill: address[1:0]=10 -> own NOHIT -> line E
        do_cmd(4'd0, 32'h0000_1002);
        check_strobes("rd_miss", 3'd1, 1'b0, 2'd2);
        check_ctrs("rd_miss", 1, 0, 0, 1);
        do_cmd(4'd0, 32'h0000_1002);
        check_strobes("rd_hit", 3'd0, 1'b0, 2'd2);
        check_ctrs("rd_hit", 2, 0, 1, 1);

        // Write upgrade E->M silently, snoop read M->S, write S->M invalidates
        do_cmd(4'd1, 32'h0000_1002);
        check_strobes("wr_e", 3'd0, 1'b0, 2'd2);
        check_ctrs("wr_e", 2, 1, 2, 1);
        do_cmd(4'd4, 32'h0000_1002);
        check_strobes("snprd_m", 3'd0, 1'b1, 2'd1);
        check_ctrs("snprd_m", 2, 1, 2, 1);
        do_cmd(4'd1, 32'h0000_1002);
        check_strobes("wr_s", 3'd3, 1'b0, 2'd2);
        check_ctrs("wr_s", 2, 2, 3, 1);
        idle();
        check_strobes("idle", 3'd0, 1'b0, 2'd2);

        // Snoop RWIM on M line, then it misses
        do_cmd(4'd6, 32'h0000_1002);
        check_strobes("rwim_m", 3'd0, 1'b1, 2'd1);
        do_cmd(4'd0, 32'h0000_1002);
        check_strobes("after_rwim", 3'd1, 1'b0, 2'd2);
        check_ctrs("after_rwim", 3, 2, 3, 2);

        // address[1:0]=00 -> own HIT -> line S; snoop read reports HIT
        do_cmd(4'd0, 32'h0000_2000);
        check_strobes("fill_s", 3'd1, 1'b0, 2'd2);
        do_cmd(4'd4, 32'h0000_2000);
        check_strobes("snprd_s", 3'd0, 1'b0, 2'd0);
        do_cmd(4'd3, 32'h0000_2000);
        do_cmd(4'd0, 32'h0000_2000);
        check_strobes("after_inv", 3'd1, 1'b0, 2'd2);
        check_ctrs("after_inv", 5, 2, 3, 4);

        // Snoop misses and snoop write always NOHIT
        do_cmd(4'd4, 32'h0000_9000);
        check_strobes("snprd_miss", 3'd0, 1'b0, 2'd2);
        do_cmd(4'd5, 32'h0000_1002);
        check_strobes("snpwr", 3'd0, 1'b0, 2'd2);

        // Ignored code and no-op dump
        do_cmd(4'd7, 32'h0000_5002);
        check_strobes("cmd7", 3'd0, 1'b0, 2'd2);
        do_cmd(4'd9, 32'h0000_0000);
        check_strobes("cmd9", 3'd0, 1'b0, 2'd2);
        check_ctrs("cmd9", 5, 2, 3, 4);

        // Clear
        do_cmd(4'd8, 32'h0000_0000);
        check_ctrs("clear", 0, 0, 0, 0);
        do_cmd(4'd0, 32'h0000_1002);
        check_strobes("clear_miss", 3'd1, 1'b0, 2'd2);
        check_ctrs("clear_miss", 1, 0, 0, 1);

        // Eviction in set 0: ways 0..3 filled, PLRU picks way 0 for 0x5002
        do_cmd(4'd0, 32'h0000_2002);
        do_cmd(4'd0, 32'h0000_3002);
        do_cmd(4'd0, 32'h0000_4002);
        check_ctrs("fill4", 4, 0, 0, 4);
        do_cmd(4'd0, 32'h0000_5002);
        check_strobes("evict", 3'd1, 1'b0, 2'd2);
        do_cmd(4'd0, 32'h0000_1002);
        check_strobes("evicted_miss", 3'd1, 1'b0, 2'd2);
        check_ctrs("evicted_miss", 6, 0, 0, 6);
        // 0x1002 replaced way 2 (0x3002), so 0x2002 in way 1 survives
        do_cmd(4'd0, 32'h0000_2002);
        check_strobes("survivor", 3'd0, 1'b0, 2'd2);
        check_ctrs("survivor", 7, 0, 1, 6);

        // Dirty eviction in set 1: write-miss fills way 0 as M, later evicted
        do_cmd(4'd1, 32'h0000_1042);
        check_strobes("wr_miss", 3'd4, 1'b0, 2'd2);
        do_cmd(4'd0, 32'h0000_2042);
        do_cmd(4'd0, 32'h0000_3042);
        do_cmd(4'd0, 32'h0000_4042);
        do_cmd(4'd0, 32'h0000_5042);
        check_strobes("dirty_evict", 3'd1, 1'b1, 2'd2);
        check_ctrs("dirty_evict", 11, 1, 1, 11);

        // Reset mid-run with a command present: dropped
        @(negedge clk);
        rst     = 1'b1;
        eof     = 1'b1;
        command = 4'd0;
        address = 32'h0000_1002;
        @(posedge clk);
        #1;
        check_ctrs("rst_mid", 0, 0, 0, 0);
        check_strobes("rst_mid", 3'd0, 1'b0, 2'd2);
        @(negedge clk);
        rst = 1'b0;
        eof = 1'b0;
        do_cmd(4'd0, 32'h0000_2002);
        check_strobes("post_rst", 3'd1, 1'b0, 2'd2);
        check_ctrs("post_rst", 1, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
